// File: rtl/a_stream_pkg.sv
// rtl/a_stream_pkg.sv - shared defaults, pointer width helper and beat type for a_stream_fifo
package a_stream_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  // Extra MSB over the storage index is the wrap bit that separates full from empty
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_DATA_W-1:0] a;
  } a_beat_t;

endpackage

// File: rtl/a_stream_fifo_mem.sv
// rtl/a_stream_fifo_mem.sv - DEPTH x DATA_W register array, sync write, combinational read
module a_stream_fifo_mem
  import a_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  // Storage is deliberately not reset; the pointers alone define validity
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/a_stream_fifo.sv
// rtl/a_stream_fifo.sv - valid/ready stream FIFO; A_STREAM_FIFO_LEVEL_EN adds level/almost_full ports
module a_stream_fifo
  import a_stream_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_a,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_a,
`ifdef A_STREAM_FIFO_LEVEL_EN
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      almost_full,
`endif
  input  logic                      out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_param_check
    $error("a_stream_fifo: illegal DATA_W/DEPTH/AF_LEVEL");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full && !reset;
  assign out_valid = !empty;

  // A pop during reset is irrelevant because both pointers clear on that edge
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  a_stream_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock(clock),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(in_a),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(out_a)
  );

`ifdef A_STREAM_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (level >= AF_THRESH);
`endif

endmodule
